// File: rtl/mips32_pkg.sv
// Shared types for the MIPS32 hazard interlock: register index,
// scoreboard entry layout and forward-select encoding.
package mips32_pkg;

    localparam int NREG_DEFAULT = 32;
    localparam int RIDX_W = $clog2(NREG_DEFAULT);

    typedef logic [RIDX_W-1:0] reg_idx_t;

    typedef struct packed {
        logic     vld;
        reg_idx_t rd;
        logic     ld;
    } sb_entry_t;

    localparam int FWD_RF = 0;

endpackage

// File: rtl/mips32_hazard_scoreboard_if.sv
// ID-stage hazard handshake bundle: the decoder side drives the
// instruction fields, the scoreboard answers with stall/issue/forward.
interface mips32_hazard_scoreboard_if #(
    parameter int NREG       = 32,
    parameter int PIPE_DEPTH = 3,
    parameter int CNT_W      = 16
);
    localparam int RW = $clog2(NREG);
    localparam int FW = $clog2(PIPE_DEPTH + 1);

    logic          id_valid;
    logic [RW-1:0] id_rs;
    logic [RW-1:0] id_rt;
    logic          id_use_rs;
    logic          id_use_rt;
    logic          id_wr_en;
    logic [RW-1:0] id_rd;
    logic          id_is_load;
    logic          flush;
    logic          stall;
    logic          issue;
    logic [FW-1:0] fwd_sel_rs;
    logic [FW-1:0] fwd_sel_rt;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
        output id_wr_en, id_rd, id_is_load, flush,
        input  stall, issue, fwd_sel_rs, fwd_sel_rt, stall_cnt
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
        input  id_wr_en, id_rd, id_is_load, flush,
        output stall, issue, fwd_sel_rs, fwd_sel_rt, stall_cnt
    );

endinterface

// File: rtl/mips32_haz_match.sv
// Compares one source register against every scoreboard entry and
// reports the hit vector, youngest hit index and load-use condition.
module mips32_haz_match
    import mips32_pkg::*;
#(
    parameter int PIPE_DEPTH = 3,
    localparam int YW = $clog2(PIPE_DEPTH)
) (
    input  logic                        use_src,
    input  reg_idx_t                    src,
    input  sb_entry_t [PIPE_DEPTH-1:0]  sb,
    output logic [PIPE_DEPTH-1:0]       hit,
    output logic [YW-1:0]               youngest,
    output logic                        load_use
);

    always_comb begin
        hit      = '0;
        youngest = '0;
        for (int k = 0; k < PIPE_DEPTH; k++) begin
            hit[k] = use_src && (src != '0) && sb[k].vld
                     && (sb[k].rd == src);
        end
        // Scan oldest to youngest so the lowest index wins.
        for (int k = PIPE_DEPTH - 1; k >= 0; k--) begin
            if (hit[k]) youngest = YW'(k);
        end
        load_use = hit[0] && sb[0].ld;
    end

endmodule

// File: rtl/mips32_hazard_scoreboard.sv
// RAW hazard interlock at ID using a shift-register scoreboard.
// Define MIPS32_HAZ_FWD_EN to generate forward selects instead of stalling.
module mips32_hazard_scoreboard
    import mips32_pkg::*;
#(
    parameter int NREG       = 32,
    parameter int PIPE_DEPTH = 3,
    parameter int CNT_W      = 16
) (
    input  logic clk1,
    input  logic reset,
    mips32_hazard_scoreboard_if.slave bus
);

    localparam int FW = $clog2(PIPE_DEPTH + 1);
    localparam int YW = $clog2(PIPE_DEPTH);
    localparam logic [PIPE_DEPTH-1:0] EARLY =
        PIPE_DEPTH'((1 << (PIPE_DEPTH - 1)) - 1);

    sb_entry_t [PIPE_DEPTH-1:0] sb;
    sb_entry_t                  new_e;
    logic [CNT_W-1:0]           cnt;

    reg_idx_t rs;
    reg_idx_t rt;
    reg_idx_t rd;

    logic [PIPE_DEPTH-1:0] hit_rs;
    logic [PIPE_DEPTH-1:0] hit_rt;
    logic [YW-1:0]         y_rs;
    logic [YW-1:0]         y_rt;
    logic                  lu_rs;
    logic                  lu_rt;

    logic          live;
    logic          haz;
    logic [FW-1:0] fwd_rs;
    logic [FW-1:0] fwd_rt;

    assign rs = reg_idx_t'(bus.id_rs);
    assign rt = reg_idx_t'(bus.id_rt);
    assign rd = reg_idx_t'(bus.id_rd);

    mips32_haz_match #(.PIPE_DEPTH(PIPE_DEPTH)) u_match_rs (
        .use_src  (bus.id_use_rs),
        .src      (rs),
        .sb       (sb),
        .hit      (hit_rs),
        .youngest (y_rs),
        .load_use (lu_rs)
    );

    mips32_haz_match #(.PIPE_DEPTH(PIPE_DEPTH)) u_match_rt (
        .use_src  (bus.id_use_rt),
        .src      (rt),
        .sb       (sb),
        .hit      (hit_rt),
        .youngest (y_rt),
        .load_use (lu_rt)
    );

    assign live = bus.id_valid && !bus.flush;

`ifdef MIPS32_HAZ_FWD_EN
    // Only a load still in entry 0 cannot be forwarded yet.
    assign haz = lu_rs || lu_rt;

    always_comb begin
        fwd_rs = FW'(FWD_RF);
        fwd_rt = FW'(FWD_RF);
        if (live && |(hit_rs & EARLY)) fwd_rs = FW'(y_rs) + FW'(1);
        if (live && |(hit_rt & EARLY)) fwd_rt = FW'(y_rt) + FW'(1);
    end
`else
    logic fwd_unused;

    assign haz        = |((hit_rs | hit_rt) & EARLY);
    assign fwd_rs     = FW'(FWD_RF);
    assign fwd_rt     = FW'(FWD_RF);
    assign fwd_unused = ^{y_rs, y_rt, lu_rs, lu_rt};
`endif

    assign bus.stall      = live && haz;
    assign bus.issue      = live && !haz;
    assign bus.fwd_sel_rs = fwd_rs;
    assign bus.fwd_sel_rt = fwd_rt;
    assign bus.stall_cnt  = cnt;

    always_comb begin
        new_e = '0;
        if (bus.issue && bus.id_wr_en && (rd != '0)) begin
            new_e.vld = 1'b1;
            new_e.rd  = rd;
            new_e.ld  = bus.id_is_load;
        end
    end

    always_ff @(posedge clk1 or posedge reset) begin
        if (reset) begin
            sb  <= '0;
            cnt <= '0;
        end else begin
            sb <= {sb[PIPE_DEPTH-2:0], new_e};
            if (bus.stall && (cnt != '1)) cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: doc/mips32_hazard_scoreboard.md
# mips32_hazard_scoreboard

Parametrised hazard interlock for the pipelined MIPS32 core, placed at the ID stage. It tracks destination registers of in-flight instructions in a shift-register scoreboard and stalls issue on read-after-write hazards. With this block, test programs no longer need dummy OR instructions between dependent instructions. Pipeline depth, register count and optional forwarding-select generation are configurable.

## Interface

**Parameters**
- NREG, 32, architectural register count; R0 is hardwired zero.
- PIPE_DEPTH, 3, number of stages between ID and WB inclusive (EX, MEM, WB = 3); minimum 2.
- CNT_W, 16, width of the stall counter.

**Ports**
- clk1  in  1  single pipeline clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- id_valid  in  1  ID holds a real instruction.
- id_rs  in  $clog2(NREG)  first source register.
- id_rt  in  $clog2(NREG)  second source register.
- id_use_rs  in  1  instruction reads rs.
- id_use_rt  in  1  instruction reads rt.
- id_wr_en  in  1  instruction writes a register.
- id_rd  in  $clog2(NREG)  destination register.
- id_is_load  in  1  instruction is a load; result is available only after MEM.
- flush  in  1  taken branch: kill the instruction in ID.
- stall  out  1  hold IF/ID and inject a bubble into EX.
- issue  out  1  id_valid & ~stall & ~flush.
- fwd_sel_rs  out  $clog2(PIPE_DEPTH+1)  forward source for rs; 0 selects the register file.
- fwd_sel_rt  out  $clog2(PIPE_DEPTH+1)  forward source for rt.
- stall_cnt  out  CNT_W  saturating count of stall cycles.

## Operation

- **Scoreboard:** PIPE_DEPTH entries. Entry k holds {vld, rd, ld} for the instruction k+1 stages past ID. Entry PIPE_DEPTH-1 is in WB.
- **Shift:** every cycle, entry k+1 ← entry k.
- **Load into entry 0:**
  - {1, id_rd, id_is_load} when issue & id_wr_en & (id_rd ≠ 0).
  - Otherwise a bubble: vld=0.
- **Match:** a source matches entry k when:
  - its use bit is set, and
  - the source register ≠ 0, and
  - entry k.vld is set, and
  - entry k.rd equals the source register.
- **WB entry:** entry PIPE_DEPTH-1 never causes a stall. The register file is write-before-read within a cycle.
- **stall (without forwarding):** id_valid & ~flush & (any source matches any entry k < PIPE_DEPTH-1).
- **flush:** forces stall=0 and issue=0. Entry 0 receives a bubble. Older entries shift normally.
- **stall_cnt:** increments on each stall cycle and saturates at 2^CNT_W−1.
- **fwd_sel:** held at 0 unless MIPS32_HAZ_FWD_EN is defined.

## Timing

- stall, issue and fwd_sel are combinational from the ID inputs and registered entries, with no added latency. Scoreboard update takes effect on the next edge.
- **Reset values:** all entries vld=0, stall_cnt=0. With id_valid=0, outputs are stall=0, issue=0, fwd_sel_*=0.
- **Reset mid-operation:** entries clear immediately, so stall drops in the same cycle. Instructions in flight at reset are forgotten.
- **Dependence latency:** a producer issued at edge t into entry 0 blocks a dependent consumer during cycles t+1 … t+PIPE_DEPTH-1. That gives PIPE_DEPTH-1 stall cycles for back-to-back instructions without forwarding.
- **Multiple matches:** the youngest entry (lowest k) wins.
- **Same source twice:** rs = rt is handled; each source is evaluated independently.
- **Simultaneous stall and flush:** flush wins.

## Configuration

- **MIPS32_HAZ_FWD_EN defined:**
  - A match on entry k < PIPE_DEPTH-1 does not stall. fwd_sel = k+1 for the youngest match.
  - **Exception:** a match on entry 0 with ld=1 stalls for one cycle (load-use). On the next cycle fwd_sel selects entry 1.
  - A match only on the WB entry gives fwd_sel=0.
- **Undefined:** the full interlock described in Operation applies, and fwd_sel_* are constant 0.

## Structure

- **Shared package mips32_pkg:**
  - NREG_DEFAULT and the register-index typedef reg_idx_t.
  - Scoreboard entry struct sb_entry_t {vld, rd, ld}.
  - Forward-select encoding constant FWD_RF=0.
- **Sub-module mips32_haz_match:** compares one source against all entries. It returns the match vector, the youngest index, and the load-use flag. It is instantiated twice, for rs and rt.

## Test plan

1. **Back-to-back dependence, no forwarding (PIPE_DEPTH=3):** ADD R4,R1,R2 then ADD R5,R4,R3 → stall high exactly 2 cycles, then issue; stall_cnt=2.
2. **Same pair with MIPS32_HAZ_FWD_EN:** → 0 stalls; fwd_sel_rs=1 on the consumer cycle, fwd_sel_rt=0.
3. **Load-use with forwarding:** LW R6,0(R1) then ADD R7,R6,R6 → 1 stall cycle, then fwd_sel_rs=fwd_sel_rt=2.
4. **R0 destination or flush:** ADDI R0,R0,5 then ADD R1,R0,R0 → no stall. A producer in ID with flush=1 leaves no entry, so a later reader of its rd does not stall.
5. **Reset mid-stall:** assert reset during the 1st stall cycle of scenario 1 → stall=0 in the same cycle, stall_cnt=0, all entries invalid.
6. **Counter saturation (CNT_W=4):** 20 consecutive stall cycles → stall_cnt holds 15.
